// File: rtl/dpi_call_initiator.sv
// dpi_call_initiator: issues selector+argument calls to the host bridge, waits for
// the tagged result (or a timeout) and hands it back to local logic.
//  clk, rst_n                       clock, asynchronous active-low reset
//  call_valid/ready, call_fn/arg    local call request (accepted only in IDLE)
//  ret_valid/ready, ret_data/err    result back to local side (err = timed out)
//  hreq_valid/ready, hreq_fn/tag/arg  request to host bridge
//  hrsp_valid, hrsp_tag/data        host response strobe, no backpressure
//  busy                             call in flight
//  stale_cnt                        dropped responses, saturating at 255
module dpi_call_initiator #(
  parameter int DATA_W  = 32,
  parameter int FN_W    = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              call_valid,
  output logic              call_ready,
  input  logic [FN_W-1:0]   call_fn,
  input  logic [DATA_W-1:0] call_arg,
  output logic              ret_valid,
  input  logic              ret_ready,
  output logic [DATA_W-1:0] ret_data,
  output logic              ret_err,
  output logic              hreq_valid,
  input  logic              hreq_ready,
  output logic [FN_W-1:0]   hreq_fn,
  output logic [TAG_W-1:0]  hreq_tag,
  output logic [DATA_W-1:0] hreq_arg,
  input  logic              hrsp_valid,
  input  logic [TAG_W-1:0]  hrsp_tag,
  input  logic [DATA_W-1:0] hrsp_data,
  output logic              busy,
  output logic [7:0]        stale_cnt
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic hit, expire;
  // hit is only meaningful in WAIT; hreq_tag doubles as the current-call tag
  assign hit    = hrsp_valid && (hrsp_tag == hreq_tag);
  // timer counts completed WAIT cycles, so this is the TIMEOUT-th WAIT cycle
  assign expire = timer == TMR_W'(TIMEOUT - 1);
  assign call_ready = state == S_IDLE;
  assign hreq_valid = state == S_ISSUE;
  assign ret_valid  = state == S_DONE;
  assign busy       = state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = call_valid     ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nxt = hreq_ready     ? S_WAIT  : S_ISSUE;
      S_WAIT:  state_nxt = hit || expire  ? S_DONE  : S_WAIT;
      S_DONE:  state_nxt = ret_ready      ? S_IDLE  : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hreq_fn   <= '0;
      hreq_arg  <= '0;
      hreq_tag  <= '0;
      timer     <= '0;
      ret_data  <= '0;
      ret_err   <= 1'b0;
      stale_cnt <= '0;
    end else begin
      if (state == S_IDLE && call_valid) begin
        hreq_fn  <= call_fn;
        hreq_arg <= call_arg;
      end
      if (state == S_ISSUE && hreq_ready) timer <= '0;
      if (state == S_WAIT) begin
        timer <= timer + 1'b1;
        // a match in the expiry cycle takes priority over the timeout
        if (hit) begin
          ret_data <= hrsp_data;
          ret_err  <= 1'b0;
        end else if (expire) begin
          ret_data <= '0;
          ret_err  <= 1'b1;
        end
      end
      if (state == S_DONE && ret_ready) hreq_tag <= hreq_tag + 1'b1;
      if (hrsp_valid && !(state == S_WAIT && hit) && stale_cnt != 8'hff)
        stale_cnt <= stale_cnt + 8'd1;
    end
endmodule

// File: tb/tb_dpi_call_initiator.sv
// tb_dpi_call_initiator: directed self-checking bench for dpi_call_initiator (TIMEOUT=8).
module tb_dpi_call_initiator;
  logic clk = 0, rst_n = 0;
  logic call_valid = 0, ret_ready = 0, hreq_ready = 0, hrsp_valid = 0;
  logic [3:0] call_fn = 0, hrsp_tag = 0;
  logic [31:0] call_arg = 0, hrsp_data = 0;
  logic call_ready, ret_valid, ret_err, hreq_valid, busy;
  logic [31:0] ret_data, hreq_arg;
  logic [3:0] hreq_fn, hreq_tag;
  logic [7:0] stale_cnt;
  int checks = 0, failures = 0;
  int exp_stale = 0;

  dpi_call_initiator #(.DATA_W(32), .FN_W(4), .TAG_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .call_valid(call_valid), .call_ready(call_ready), .call_fn(call_fn), .call_arg(call_arg),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_data(ret_data), .ret_err(ret_err),
    .hreq_valid(hreq_valid), .hreq_ready(hreq_ready), .hreq_fn(hreq_fn), .hreq_tag(hreq_tag),
    .hreq_arg(hreq_arg), .hrsp_valid(hrsp_valid), .hrsp_tag(hrsp_tag), .hrsp_data(hrsp_data),
    .busy(busy), .stale_cnt(stale_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drives a call that is accepted on the next edge; leaves the block in ISSUE
  task automatic start_call(input logic [3:0] fn, input logic [31:0] arg);
    call_valid = 1; call_fn = fn; call_arg = arg;
    step();
    call_valid = 0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (call_ready !== 1'b1) begin failures++; $display("FAIL reset_call_ready got=%0b exp=1", call_ready); end
    checks++; if ({busy, hreq_valid, ret_valid, ret_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, hreq_valid, ret_valid, ret_err}); end
    checks++; if ({hreq_fn, hreq_tag, hreq_arg, ret_data, stale_cnt} !== '0) begin failures++; $display("FAIL reset_data fn=%0h tag=%0h arg=%0h ret=%0h stale=%0d exp all 0", hreq_fn, hreq_tag, hreq_arg, ret_data, stale_cnt); end
    rst_n = 1;
    step();
  endtask

  task automatic test_basic();
    hreq_ready = 1;
    start_call(4'd2, 32'd3);
    checks++; if ({hreq_valid, busy, call_ready} !== 3'b110) begin failures++; $display("FAIL basic_issue_flags got=%b exp=110", {hreq_valid, busy, call_ready}); end
    checks++; if ({hreq_fn, hreq_tag, hreq_arg} !== {4'd2, 4'd0, 32'd3}) begin failures++; $display("FAIL basic_req fn=%0d tag=%0d arg=%0d exp 2/0/3", hreq_fn, hreq_tag, hreq_arg); end
    step();
    hreq_ready = 0;
    hrsp_valid = 1; hrsp_tag = 4'd0; hrsp_data = 32'd7;
    step();
    hrsp_valid = 0;
    checks++; if ({ret_valid, ret_err, ret_data} !== {1'b1, 1'b0, 32'd7}) begin failures++; $display("FAIL basic_ret valid=%0b err=%0b data=%0d exp 1/0/7", ret_valid, ret_err, ret_data); end
    ret_ready = 1;
    step();
    ret_ready = 0;
    checks++; if ({call_ready, ret_valid, hreq_tag} !== {1'b1, 1'b0, 4'd1}) begin failures++; $display("FAIL basic_after ready=%0b valid=%0b tag=%0d exp 1/0/1", call_ready, ret_valid, hreq_tag); end
  endtask

  task automatic test_stall();
    int k;
    start_call(4'd5, 32'hA5A5_0001);
    call_fn = 4'd9; call_arg = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({hreq_valid, hreq_fn, hreq_tag, hreq_arg} !== {1'b1, 4'd5, 4'd1, 32'hA5A5_0001}) begin failures++; $display("FAIL stall_hold_%0d v=%0b fn=%0h tag=%0h arg=%0h", i, hreq_valid, hreq_fn, hreq_tag, hreq_arg); end
      step();
    end
    hreq_ready = 1;
    step();
    hreq_ready = 0;
    k = 0;
    for (int j = 1; j <= 20 && k == 0; j++) begin
      step();
      if (ret_valid) k = j;
    end
    checks++; if (k !== 8) begin failures++; $display("FAIL stall_timeout_cycles got=%0d exp=8", k); end
    checks++; if ({ret_err, ret_data} !== {1'b1, 32'd0}) begin failures++; $display("FAIL stall_timeout_ret err=%0b data=%0h exp 1/0", ret_err, ret_data); end
    ret_ready = 1;
    step();
    ret_ready = 0;
  endtask

  task automatic test_timeout();
    int k;
    hreq_ready = 1;
    start_call(4'd1, 32'd9);
    checks++; if (hreq_tag !== 4'd2) begin failures++; $display("FAIL timeout_tag got=%0d exp=2", hreq_tag); end
    step();
    hreq_ready = 0;
    k = 0;
    for (int j = 1; j <= 20 && k == 0; j++) begin
      step();
      if (ret_valid) k = j;
    end
    checks++; if (k !== 8) begin failures++; $display("FAIL timeout_cycles got=%0d exp=8", k); end
    checks++; if ({ret_err, ret_data} !== {1'b1, 32'd0}) begin failures++; $display("FAIL timeout_ret err=%0b data=%0h exp 1/0", ret_err, ret_data); end
    ret_ready = 1;
    step();
    ret_ready = 0;
    hrsp_valid = 1; hrsp_tag = 4'd2; hrsp_data = 32'h55;
    step();
    hrsp_valid = 0;
    exp_stale++;
    checks++; if (stale_cnt !== 8'(exp_stale)) begin failures++; $display("FAIL timeout_late_stale got=%0d exp=%0d", stale_cnt, exp_stale); end
  endtask

  task automatic test_wrong_tag();
    hreq_ready = 1;
    start_call(4'd3, 32'd33);
    step();
    hreq_ready = 0;
    hrsp_valid = 1; hrsp_tag = 4'd4; hrsp_data = 32'd111;
    step();
    exp_stale++;
    checks++; if ({ret_valid, stale_cnt} !== {1'b0, 8'(exp_stale)}) begin failures++; $display("FAIL wrong_tag_drop valid=%0b stale=%0d exp 0/%0d", ret_valid, stale_cnt, exp_stale); end
    hrsp_tag = 4'd3; hrsp_data = 32'd222;
    step();
    checks++; if ({ret_valid, ret_err, ret_data} !== {1'b1, 1'b0, 32'd222}) begin failures++; $display("FAIL wrong_tag_ret valid=%0b err=%0b data=%0d exp 1/0/222", ret_valid, ret_err, ret_data); end
    hrsp_data = 32'd999;
    step();
    hrsp_valid = 0;
    exp_stale++;
    checks++; if ({ret_data, stale_cnt} !== {32'd222, 8'(exp_stale)}) begin failures++; $display("FAIL done_stale data=%0d stale=%0d exp 222/%0d", ret_data, stale_cnt, exp_stale); end
    ret_ready = 1;
    step();
    ret_ready = 0;
  endtask

  task automatic test_expiry_race();
    hreq_ready = 1;
    start_call(4'd4, 32'd44);
    step();
    hreq_ready = 0;
    for (int j = 0; j < 7; j++) step();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL race_early got=%0b exp=0", ret_valid); end
    hrsp_valid = 1; hrsp_tag = 4'd4; hrsp_data = 32'hCAFE;
    step();
    hrsp_valid = 0;
    checks++; if ({ret_valid, ret_err, ret_data, stale_cnt} !== {1'b1, 1'b0, 32'hCAFE, 8'(exp_stale)}) begin failures++; $display("FAIL race_ret valid=%0b err=%0b data=%0h stale=%0d exp 1/0/cafe/%0d", ret_valid, ret_err, ret_data, stale_cnt, exp_stale); end
    ret_ready = 1;
    step();
    ret_ready = 0;
  endtask

  task automatic test_async_reset();
    hreq_ready = 1;
    start_call(4'd6, 32'd66);
    step();
    hreq_ready = 0;
    checks++; if ({busy, hreq_tag} !== {1'b1, 4'd5}) begin failures++; $display("FAIL areset_pre busy=%0b tag=%0d exp 1/5", busy, hreq_tag); end
    #2 rst_n = 0;
    #1;
    checks++; if ({busy, hreq_valid, ret_valid, ret_err, call_ready} !== 5'b00001) begin failures++; $display("FAIL areset_flags got=%b exp=00001", {busy, hreq_valid, ret_valid, ret_err, call_ready}); end
    checks++; if ({hreq_fn, hreq_tag, hreq_arg, ret_data, stale_cnt} !== '0) begin failures++; $display("FAIL areset_data fn=%0h tag=%0h arg=%0h ret=%0h stale=%0d exp all 0", hreq_fn, hreq_tag, hreq_arg, ret_data, stale_cnt); end
    step(); step();
    rst_n = 1;
    step(); step();
    checks++; if (ret_valid !== 1'b0) begin failures++; $display("FAIL areset_no_ret got=%0b exp=0", ret_valid); end
    start_call(4'd7, 32'd77);
    checks++; if ({hreq_valid, hreq_tag} !== {1'b1, 4'd0}) begin failures++; $display("FAIL areset_next_tag valid=%0b tag=%0d exp 1/0", hreq_valid, hreq_tag); end
    hreq_ready = 1;
    step();
    hreq_ready = 0;
    hrsp_valid = 1; hrsp_tag = 4'd0; hrsp_data = 32'd70;
    step();
    hrsp_valid = 0;
    ret_ready = 1;
    step();
    ret_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] et;
    hreq_ready = 1;
    for (int i = 0; i < 17; i++) begin
      et = 4'((i + 1) % 16);
      start_call(4'(i), 32'(i * 3));
      checks++; if ({hreq_tag, hreq_fn, hreq_arg} !== {et, 4'(i), 32'(i * 3)}) begin failures++; $display("FAIL b2b_req_%0d tag=%0d fn=%0d arg=%0d exp %0d/%0d/%0d", i, hreq_tag, hreq_fn, hreq_arg, et, i % 16, i * 3); end
      step();
      hrsp_valid = 1; hrsp_tag = et; hrsp_data = 32'(i + 100);
      step();
      hrsp_valid = 0;
      checks++; if ({ret_valid, ret_err, ret_data} !== {1'b1, 1'b0, 32'(i + 100)}) begin failures++; $display("FAIL b2b_ret_%0d valid=%0b err=%0b data=%0d exp 1/0/%0d", i, ret_valid, ret_err, ret_data, i + 100); end
      if (i == 5) begin
        for (int h = 0; h < 3; h++) begin
          step();
          checks++; if ({ret_valid, call_ready, ret_data} !== {1'b1, 1'b0, 32'd105}) begin failures++; $display("FAIL b2b_hold_%0d valid=%0b ready=%0b data=%0d exp 1/0/105", h, ret_valid, call_ready, ret_data); end
        end
      end
      ret_ready = 1;
      step();
      ret_ready = 0;
      checks++; if (call_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%0b exp=1", i, call_ready); end
    end
    hreq_ready = 0;
    checks++; if (hreq_tag !== 4'd2) begin failures++; $display("FAIL b2b_final_tag got=%0d exp=2", hreq_tag); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_wrong_tag();
    test_expiry_race();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
